conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 6 +
 rtl/conv_line_buf.sv | 18 +
 rtl/conv_window_gen.sv | 57 +++++
 tb/tb_conv_window_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FP16 width, kernel size and 3x3 window type for the conv datapath
package conv_pkg;
  localparam int FP16_W = 16;
  localparam int KERNEL = 3;
  typedef logic [KERNEL*KERNEL-1:0][FP16_W-1:0] win_t;
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: single-port read-before-write line buffer (clk, we, addr, wdata in; rdata out = old mem[addr])
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [FP16_W-1:0]        wdata,
  output logic [FP16_W-1:0]        rdata
);
  logic [FP16_W-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster FP16 stream (in_valid/in_ready/in_data) to valid-padded 3x3 windows (out_valid/out_ready/win_data/win_last)
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output win_t              win_data,
  output logic              win_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_t win_q, win_d;
  logic out_valid_q, out_valid_d, win_last_q, win_last_d;
  logic acc, col_end, row_end;
  logic [FP16_W-1:0] l0_rd, l1_rd;
  assign in_ready = !rst && !(out_valid_q && !out_ready);
  assign acc = in_valid && in_ready;
  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == RW'(IMG_H - 1);
  assign out_valid = out_valid_q;
  assign win_data = win_q;
  assign win_last = win_last_q;
  conv_line_buf #(.DEPTH(IMG_W)) u_line0 (.clk(clk), .we(acc), .addr(col_q), .wdata(in_data), .rdata(l0_rd));
  conv_line_buf #(.DEPTH(IMG_W)) u_line1 (.clk(clk), .we(acc), .addr(col_q), .wdata(l0_rd), .rdata(l1_rd));
  always_comb begin
    col_d = acc ? (col_end ? '0 : col_q + 1'b1) : col_q;
    row_d = (acc && col_end) ? (row_end ? '0 : row_q + 1'b1) : row_q;
    win_d = acc ? {in_data, win_q[8:7], l0_rd, win_q[5:4], l1_rd, win_q[2:1]} : win_q;
    out_valid_d = acc ? (row_q >= RW'(2) && col_q >= CW'(2)) : (out_valid_q && !out_ready);
    win_last_d = acc ? (row_end && col_end) : (win_last_q && out_valid_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      out_valid_q <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      out_valid_q <= out_valid_d;
      win_last_q <= win_last_d;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized self-checking bench against a frame-level window model
module tb_conv_window_gen;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;
  typedef logic [8:0][15:0] win_t;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [15:0] in_data = 0;
  logic out_valid;
  logic out_ready = 1;
  win_t win_data;
  logic win_last;
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [15:0] frame [N];
  win_t got_w[$], exp_w[$];
  bit got_l[$], exp_l[$];
  int got_cyc[$], acc_cyc[$];
  win_t first_win;
  bit bp_on;

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .win_data(win_data), .win_last(win_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) acc_cyc.push_back(cyc);
    if (!rst && out_valid && out_ready) begin
      got_w.push_back(win_data);
      got_l.push_back(win_last);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic clear_q();
    got_w.delete(); exp_w.delete(); got_l.delete(); exp_l.delete(); got_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic make_frame(input int base, input bit rnd);
    for (int i = 0; i < N; i++) frame[i] = rnd ? 16'($urandom) : 16'(base + i);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        win_t w;
        for (int k = 0; k < 9; k++) w[k] = frame[(r - 2 + k / 3) * W + c - 2 + k % 3];
        exp_w.push_back(w);
        exp_l.push_back(r == H - 1 && c == W - 1);
      end
  endtask

  task automatic send_pixel(input logic [15:0] d);
    int n = 0;
    in_valid = 1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_frame(input bit gaps, input int count);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      send_pixel(frame[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (got_w.size() < exp_w.size() && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready); else passed++;
    checks++; if (win_last !== 1'b0) $display("FAIL reset_win_last got %b required 0", win_last); else passed++;
    checks++; if (win_data !== '0) $display("FAIL reset_win_data got %h required 0", win_data); else passed++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic();
    clear_q();
    make_frame(0, 0);
    send_frame(0, N);
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL basic_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL basic_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
    if (got_w.size() > 0 && acc_cyc.size() > 12) begin
      checks++; if (got_w[0] !== first_win) $display("FAIL basic_first got %h required %h", got_w[0], first_win); else passed++;
      checks++; if (got_cyc[0] != acc_cyc[12] + 1) $display("FAIL basic_latency got cycle %0d required %0d", got_cyc[0], acc_cyc[12] + 1); else passed++;
    end
  endtask

  task automatic test_stall();
    clear_q();
    make_frame(0, 0);
    out_ready = 0;
    fork
      send_frame(0, N);
      begin
        int n = 0;
        win_t w0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        checks++; if (out_valid !== 1'b1) $display("FAIL stall_wait out_valid=%b required 1", out_valid); else passed++;
        w0 = win_data;
        checks++; if (w0 !== first_win) $display("FAIL stall_first got %h required %h", w0, first_win); else passed++;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (out_valid !== 1'b1 || win_data !== w0 || in_ready !== 1'b0)
            $display("FAIL stall_hold%0d got valid %b ready %b data %h required 1 0 %h", k, out_valid, in_ready, win_data, w0);
          else passed++;
          if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL stall_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL stall_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_gaps();
    clear_q();
    make_frame(0, 0);
    send_frame(1, N);
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL gaps_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL gaps_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    win_t second;
    for (int k = 0; k < 9; k++) second[k] = 16'(100 + (k / 3) * W + k % 3);
    clear_q();
    make_frame(0, 0);
    send_frame(0, N);
    make_frame(100, 0);
    send_frame(0, N);
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL b2b_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL b2b_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
    if (got_w.size() > 9) begin
      checks++; if (got_w[9] !== second) $display("FAIL b2b_second_first got %h required %h", got_w[9], second); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    clear_q();
    make_frame(0, 0);
    send_frame(0, 18);
    rst = 1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || win_last !== 1'b0 || win_data !== '0)
        $display("FAIL midrst_%0d got valid %b ready %b last %b data %h required 0 0 0 0", k, out_valid, in_ready, win_last, win_data);
      else passed++;
    end
    @(posedge clk); #1;
    rst = 0;
    clear_q();
    make_frame(0, 0);
    send_frame(0, N);
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL midrst_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL midrst_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  task automatic test_random_backpressure();
    clear_q();
    make_frame(0, 1);
    bp_on = 1;
    fork
      begin
        send_frame(1, N);
        bp_on = 0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1;
      end
    join
    drain();
    checks++; if (got_w.size() != exp_w.size()) $display("FAIL rbp_count got %0d required %0d", got_w.size(), exp_w.size()); else passed++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) $display("FAIL rbp_win%0d got %h last %b required %h last %b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      else passed++;
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) first_win[k] = 16'((k / 3) * W + k % 3);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_random_backpressure();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
